rca: RTL and testbench

RCA -- requirements
Module: rca

---
 rtl/rca.sv | 54 +++++
 tb/tb_rca.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rca.sv
// Ripple-carry adder with combinational outputs and a registered result stage.
// The adder is an explicit chain of full-adder cells. The registered copy
// loads one result for each cycle in which valid_i is high.
module rca #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic [WIDTH-1:0] sum_q_o,
  output logic             carry_q_o,
  output logic             overflow_q_o,
  output logic             valid_o
);

  // carry_chain[i] is the carry into bit i; carry_chain[WIDTH] leaves the MSB
  logic [WIDTH:0] carry_chain;

  assign carry_chain[0] = carry_i;

  // One full-adder cell per bit, each fed by the carry of the cell below it
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum_o[i]           = a_i[i] ^ b_i[i] ^ carry_chain[i];
    assign carry_chain[i+1]   = (a_i[i] & b_i[i]) | (carry_chain[i] & (a_i[i] ^ b_i[i]));
  end

  // Signed overflow: the carries into and out of the MSB disagree
  assign carry_o    = carry_chain[WIDTH];
  assign overflow_o = carry_chain[WIDTH-1] ^ carry_chain[WIDTH];

  // Capture the adder result when valid_i is high; reset wins over valid_i
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sum_q_o      <= '0;
      carry_q_o    <= 1'b0;
      overflow_q_o <= 1'b0;
      valid_o      <= 1'b0;
    end else if (valid_i) begin
      sum_q_o      <= sum_o;
      carry_q_o    <= carry_o;
      overflow_q_o <= overflow_o;
      valid_o      <= 1'b1;
    end else begin
      valid_o      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rca.sv
// Testbench for rca. It checks the combinational adder directly against an
// arithmetic reference. It also checks the registered stage with a scoreboard.
// The driver pushes the expected register contents after each edge, and a
// monitor pops and compares them on the following falling edge.
module tb_rca;
  localparam int WIDTH = 4;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             carry_i;
  logic             valid_i;
  logic [WIDTH-1:0] sum_o;
  logic             carry_o;
  logic             overflow_o;
  logic [WIDTH-1:0] sum_q_o;
  logic             carry_q_o;
  logic             overflow_q_o;
  logic             valid_o;

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
  } exp_t;

  exp_t exp_q[$];
  exp_t model_reg;
  int   checks = 0;
  int   errors = 0;
  int   accepted = 0;
  int   results_seen = 0;
  bit   mon_en = 1'b0;

  rca #(.WIDTH(WIDTH)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .a_i          (a_i),
    .b_i          (b_i),
    .carry_i      (carry_i),
    .valid_i      (valid_i),
    .sum_o        (sum_o),
    .carry_o      (carry_o),
    .overflow_o   (overflow_o),
    .sum_q_o      (sum_q_o),
    .carry_q_o    (carry_q_o),
    .overflow_q_o (overflow_q_o),
    .valid_o      (valid_o)
  );

  // Free-running clock
  always #5 clk_i = ~clk_i;

  // Arithmetic reference: plain integer sum, and signed range test for overflow
  function automatic void ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic c, output logic [WIDTH-1:0] s,
                                  output logic co, output logic ov);
    longint total, sa, sb, ss, lim;
    total = longint'(a) + longint'(b) + longint'(c);
    s     = WIDTH'(total);
    co    = (total >> WIDTH) != 0;
    lim   = longint'(1) << (WIDTH - 1);
    sa    = (longint'(a) >= lim) ? longint'(a) - 2 * lim : longint'(a);
    sb    = (longint'(b) >= lim) ? longint'(b) - 2 * lim : longint'(b);
    ss    = sa + sb + longint'(c);
    ov    = (ss > lim - 1) || (ss < -lim);
  endfunction

  // Drive operands, let them settle, and compare the combinational outputs
  task automatic check_comb(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic c, input string name);
    logic [WIDTH-1:0] es;
    logic eco, eov;
    a_i = a; b_i = b; carry_i = c;
    #1;
    ref_add(a, b, c, es, eco, eov);
    checks++;
    if (sum_o !== es || carry_o !== eco || overflow_o !== eov) begin
      errors++;
      $display("[TB] FAIL %s a=%b b=%b cin=%b: got sum=%b c=%b ov=%b, expected sum=%b c=%b ov=%b",
               name, a, b, c, sum_o, carry_o, overflow_o, es, eco, eov);
    end
  endtask

  // Apply one cycle of registered-path stimulus and push the expected state
  task automatic apply_stimulus(input logic rst_n, input logic v,
                                input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic c);
    logic [WIDTH-1:0] es;
    logic eco, eov;
    @(negedge clk_i);
    rst_ni = rst_n; valid_i = v; a_i = a; b_i = b; carry_i = c;
    @(posedge clk_i);
    ref_add(a, b, c, es, eco, eov);
    if (!rst_n) begin
      model_reg = '0;
    end else if (v) begin
      model_reg = '{v: 1'b1, s: es, c: eco, o: eov};
      accepted++;
    end else begin
      model_reg.v = 1'b0;
    end
    exp_q.push_back(model_reg);
    mon_en = 1'b1;
  endtask

  // Monitor: one expected record per clock edge, compared half a cycle later
  always @(negedge clk_i) begin
    if (mon_en) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL reg_underflow: DUT output with no expected entry, valid_o=%b", valid_o);
      end else begin
        e = exp_q.pop_front();
        if (valid_o === 1'b1) results_seen++;
        if (valid_o !== e.v || sum_q_o !== e.s || carry_q_o !== e.c || overflow_q_o !== e.o) begin
          errors++;
          $display("[TB] FAIL reg_path: got v=%b s=%b c=%b ov=%b, expected v=%b s=%b c=%b ov=%b",
                   valid_o, sum_q_o, carry_q_o, overflow_q_o, e.v, e.s, e.c, e.o);
        end
      end
    end
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_ni = 1'b0; valid_i = 1'b0; a_i = '0; b_i = '0; carry_i = 1'b0;

    // Directed combinational cases, including the all-ones boundaries
    check_comb(4'b0000, 4'b1001, 1'b0, "comb_a0_b9");
    check_comb(4'b1000, 4'b1001, 1'b1, "comb_a8_b9_c1");
    check_comb(4'b0100, 4'b1101, 1'b0, "comb_a4_b13");
    check_comb(4'b0011, 4'b1001, 1'b0, "comb_a3_b9");
    check_comb(4'b1100, 4'b1001, 1'b0, "comb_a12_b9");
    check_comb(4'b1111, 4'b1111, 1'b1, "comb_all_ones_c1");
    check_comb(4'b1111, 4'b0000, 1'b1, "comb_ones_zero_c1");

    // Exhaustive sweep; half runs with reset asserted, half with valid high
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v9;
      v9 = 9'(i);
      rst_ni  = v9[0];
      valid_i = v9[1];
      check_comb(v9[8:5], v9[4:1], v9[0], "comb_sweep");
    end

    // Registered path: reset, load, hold, reset beating valid
    apply_stimulus(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    apply_stimulus(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b1);
    apply_stimulus(1'b1, 1'b1, 4'b0100, 4'b1001, 1'b1);
    apply_stimulus(1'b1, 1'b0, 4'b1111, 4'b1111, 1'b1);
    apply_stimulus(1'b0, 1'b1, 4'b1100, 4'b1001, 1'b0);
    apply_stimulus(1'b1, 1'b1, 4'b1000, 4'b1001, 1'b1);
    apply_stimulus(1'b1, 1'b1, 4'b0111, 4'b0001, 1'b0);

    // Random traffic with back-to-back valids and occasional resets
    for (int n = 0; n < 300; n++) begin
      apply_stimulus(($urandom_range(0, 15) != 0), $urandom_range(0, 1),
                     WIDTH'($urandom), WIDTH'($urandom), $urandom_range(0, 1));
    end

    // Let the monitor consume the last entry, then check bookkeeping
    @(negedge clk_i);
    #1;
    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL reg_leftover: %0d expected entries not consumed, required 0", exp_q.size());
    end
    checks++;
    if (results_seen != accepted) begin
      errors++;
      $display("[TB] FAIL result_count: saw %0d results, required %0d", results_seen, accepted);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
